// File: rtl/fifo_wr_packer.sv
// Packs IN_W-bit upstream beats into OUT_W-bit words for a sync FIFO write port.
// A word is emitted after RATIO beats or early on s_last, zero-padded in the unused upper lanes.
module fifo_wr_packer #(
  parameter int IN_W  = 8,
  parameter int RATIO = 4,
  localparam int OUT_W = IN_W * RATIO
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [IN_W-1:0]  s_data,
  input  logic             s_last,
  output logic             wren,
  output logic [OUT_W-1:0] din,
  input  logic             full,
  output logic             busy
);

  localparam int CNT_W = $clog2(RATIO);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0] cnt;
  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] out_word;
  logic             out_vld;

  logic [OUT_W-1:0] lane_mask;
  logic [OUT_W-1:0] keep_mask;
  logic [OUT_W-1:0] placed;
  logic [OUT_W-1:0] merged;
  logic             take;
  logic             complete;
  int               lane_base;

  // Handshake: a beat transfers on a cycle where s_valid && s_ready; the FIFO
  // side is a plain strobe, wren only when a word is held and full is low.
  assign take     = s_valid && s_ready;
  assign complete = take && ((cnt == LAST_LANE) || s_last);
  assign s_ready  = !out_vld || !full;
  assign wren     = out_vld && !full;
  assign din      = out_word;
  assign busy     = out_vld || (cnt != '0);

  // lane_mask selects the current lane; keep_mask covers lanes 0..cnt so
  // everything above the final beat of a short word is forced to zero.
  always_comb begin
    lane_base = int'(cnt) * IN_W;
    lane_mask = {{(OUT_W - IN_W){1'b0}}, {IN_W{1'b1}}} << lane_base;
    placed    = ({{(OUT_W - IN_W){1'b0}}, s_data} << lane_base) & lane_mask;
    keep_mask = lane_mask | ((OUT_W'(1) << lane_base) - OUT_W'(1));
    merged    = (acc | placed) & keep_mask;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt      <= '0;
      acc      <= '0;
      out_word <= '0;
      out_vld  <= 1'b0;
    end else begin
      if (take) begin
        if (complete) begin
          acc <= '0;
          cnt <= '0;
        end else begin
          acc <= merged;
          cnt <= cnt + CNT_W'(1);
        end
      end
      // A new word can replace the pending one in the same cycle it is written.
      if (complete) begin
        out_word <= merged;
        out_vld  <= 1'b1;
      end else if (wren) begin
        out_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_packer.sv
// Bench for fifo_wr_packer (IN_W=8, RATIO=4): directed vector table, stall/reset
// sequences, a depth-4 FIFO pairing and random traffic against a word-level model.
module tb_fifo_wr_packer;

  localparam int IN_W  = 8;
  localparam int RATIO = 4;
  localparam int OUT_W = 32;

  logic             clk = 1'b0;
  logic             rstn;
  logic             s_valid;
  logic             s_ready;
  logic [IN_W-1:0]  s_data;
  logic             s_last;
  logic             wren;
  logic [OUT_W-1:0] din;
  logic             full;
  logic             busy;

  fifo_wr_packer #(.IN_W(IN_W), .RATIO(RATIO)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .wren    (wren),
    .din     (din),
    .full    (full),
    .busy    (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model ----------------
  int               n_tests  = 0;
  int               n_fail   = 0;
  int               n_writes = 0;
  logic [OUT_W-1:0] exp_q[$];
  logic [OUT_W-1:0] cur_word = '0;
  int               cur_n    = 0;
  logic             last_take;

  typedef struct {
    logic             v;
    logic [IN_W-1:0]  d;
    logic             l;
    logic             f;
    logic             wren;
    logic [OUT_W-1:0] din;
    logic             rdy;
    logic             busy;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(logic v, logic [IN_W-1:0] d, logic l, logic f,
                              logic w, logic [OUT_W-1:0] dn, logic r, logic b);
    vec_t t;
    t.v = v; t.d = d; t.l = l; t.f = f;
    t.wren = w; t.din = dn; t.rdy = r; t.busy = b;
    return t;
  endfunction

  task automatic check(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    cur_word = '0;
    cur_n    = 0;
  endtask

  // Word-level reference: a word exists from the cycle after it completes until
  // the FIFO accepts it; beats fill lanes in arrival order.
  task automatic sample();
    logic exp_wren, exp_rdy, exp_busy, tk;
    exp_wren = (exp_q.size() > 0) && !full;
    exp_rdy  = !((exp_q.size() > 0) && full);
    exp_busy = (exp_q.size() > 0) || (cur_n != 0);
    check("wren", wren, exp_wren);
    check("s_ready", s_ready, exp_rdy);
    check("busy", busy, exp_busy);
    if (wren) n_writes++;
    if (exp_wren) begin
      check("din", din, exp_q[0]);
      void'(exp_q.pop_front());
    end
    tk = s_valid && exp_rdy;
    last_take = tk;
    if (tk) begin
      cur_word = cur_word | (OUT_W'(s_data) << (IN_W * cur_n));
      cur_n++;
      if (cur_n == RATIO || s_last) begin
        exp_q.push_back(cur_word);
        cur_word = '0;
        cur_n    = 0;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [IN_W-1:0] d, input logic l, input logic f);
    s_valid = v;
    s_data  = d;
    s_last  = l;
    full    = f;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cyc(input logic v, input logic [IN_W-1:0] d, input logic l, input logic f);
    drive(v, d, l, f);
    #2;
    sample();
    step();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int stalls;
    int beats;
    int fcnt;

    rstn = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("rst_wren", wren, 1'b0);
    check("rst_din", din, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", s_ready, 1'b1);
    rstn = 1'b1;

    // Full word, early s_last, lane-0 restart and one-lane word.
    tbl[0]  = mk(1, 8'h11, 0, 0, 0, 32'h0,        1, 0);
    tbl[1]  = mk(1, 8'h22, 0, 0, 0, 32'h0,        1, 1);
    tbl[2]  = mk(1, 8'h33, 0, 0, 0, 32'h0,        1, 1);
    tbl[3]  = mk(1, 8'h44, 0, 0, 0, 32'h0,        1, 1);
    tbl[4]  = mk(0, 8'h00, 0, 0, 1, 32'h44332211, 1, 1);
    tbl[5]  = mk(0, 8'h00, 0, 0, 0, 32'h44332211, 1, 0);
    tbl[6]  = mk(1, 8'hAA, 0, 0, 0, 32'h44332211, 1, 0);
    tbl[7]  = mk(1, 8'hBB, 1, 0, 0, 32'h44332211, 1, 1);
    tbl[8]  = mk(1, 8'hCC, 0, 0, 1, 32'h0000BBAA, 1, 1);
    tbl[9]  = mk(1, 8'hDD, 1, 0, 0, 32'h0000BBAA, 1, 1);
    tbl[10] = mk(0, 8'h00, 0, 0, 1, 32'h0000DDCC, 1, 1);
    tbl[11] = mk(1, 8'h5A, 1, 0, 0, 32'h0000DDCC, 1, 0);
    tbl[12] = mk(0, 8'h00, 0, 0, 1, 32'h0000005A, 1, 1);
    tbl[13] = mk(0, 8'h00, 0, 0, 0, 32'h0000005A, 1, 0);
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].f);
      #2;
      check($sformatf("tbl%0d_wren", i), wren, tbl[i].wren);
      check($sformatf("tbl%0d_din", i), din, tbl[i].din);
      check($sformatf("tbl%0d_ready", i), s_ready, tbl[i].rdy);
      check($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
      sample();
      step();
    end

    // Pending word held against full for 5 cycles; offered beats are ignored.
    for (int i = 1; i <= 4; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'h99, 1'b1, 1'b1);
      #2;
      check("stall_wren", wren, 1'b0);
      check("stall_ready", s_ready, 1'b0);
      check("stall_din", din, 32'h04030201);
      sample();
      step();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    #2;
    check("release_wren", wren, 1'b1);
    check("release_din", din, 32'h04030201);
    sample();
    step();
    cyc(1'b0, '0, 1'b0, 1'b0);

    // Continuous stream of 16 beats.
    stalls   = 0;
    n_writes = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0);
      #2;
      if (!s_ready) stalls++;
      sample();
      step();
    end
    cyc(1'b0, '0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    check("stream_stalls", 32'(stalls), 32'd0);
    check("stream_writes", 32'(n_writes), 32'd4);

    // Reset in the middle of a partial word.
    cyc(1'b1, 8'hE1, 1'b0, 1'b0);
    cyc(1'b1, 8'hE2, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    rstn = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_wren", wren, 1'b0);
    check("midrst_ready", s_ready, 1'b1);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 1; i <= 4; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    #2;
    check("postrst_wren", wren, 1'b1);
    check("postrst_din", din, 32'h04030201);
    sample();
    step();

    // Paired with a depth-4 FIFO that is never read.
    fcnt = 0; beats = 0; stalls = 0; n_writes = 0;
    for (int c = 0; c < 60; c++) begin
      drive(beats < 24, 8'(8'h40 + beats), 1'b0, fcnt == 4);
      #2;
      if (!s_ready) stalls++;
      sample();
      if (last_take) beats++;
      if (wren) fcnt++;
      step();
    end
    check("fifo_writes", 32'(n_writes), 32'd4);
    check("fifo_beats", 32'(beats), 32'd20);
    check("fifo_stalled", 32'(stalls > 0), 32'd1);
    for (int c = 0; c < 12; c++) begin
      drive(beats < 24, 8'(8'h40 + beats), 1'b0, 1'b0);
      #2;
      sample();
      if (last_take) beats++;
      step();
    end
    check("fifo_drain_writes", 32'(n_writes), 32'd6);

    // Random traffic.
    for (int c = 0; c < 400; c++)
      cyc($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
    for (int c = 0; c < 4; c++) cyc(1'b0, '0, 1'b0, 1'b0);
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_packer.md
FIFO_WR_PACKER -- requirements
Module: fifo_wr_packer

Interface
REQ-001 SHALL have parameter IN_W, default 8, input beat width in bits.
REQ-002 SHALL have parameter RATIO, default 4, input beats per output word (power of two, >=2).
REQ-003 SHALL have derived parameter OUT_W = IN_W*RATIO, output word width; it equals the DWIDTH of the downstream sync FIFO.
REQ-004 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-005 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port s_valid  input  1  upstream beat valid.
REQ-007 SHALL have port s_ready  output  1  packer accepts beat this cycle.
REQ-008 SHALL have port s_data  input  IN_W  upstream beat data.
REQ-009 SHALL have port s_last  input  1  final beat of a packet; forces word emission.
REQ-010 SHALL have port wren  output  1  write strobe to the FIFO.
REQ-011 SHALL have port din  output  OUT_W  packed word to the FIFO.
REQ-012 SHALL have port full  input  1  FIFO full flag.
REQ-013 SHALL have port busy  output  1  high while a partial word or a pending word is held.

Function
REQ-014 SHALL accept a beat when s_valid && s_ready (a "take").
REQ-015 SHALL hold state as lane counter cnt (log2(RATIO) bits), accumulator acc (OUT_W), output register out_word (OUT_W) and flag out_vld.
REQ-016 SHALL write the k-th beat of a word into acc bits [k*IN_W +: IN_W]; the first beat goes into the LSBs.
REQ-017 SHALL increment cnt on each take, wrapping to 0 after the beat at RATIO-1.
REQ-018 SHALL complete a word on a take with cnt==RATIO-1 or s_last==1.
REQ-019 SHALL, on completion, load out_word with acc merged with the current beat and with all higher lanes zero-padded, set out_vld=1 on the next cycle, and clear acc and cnt.
REQ-020 SHALL drive wren = out_vld && !full combinationally and drive din = out_word.
REQ-021 SHALL clear out_vld when wren is high and no completing take occurs in the same cycle; if both occur, out_vld stays 1 and out_word takes the new word.
REQ-022 SHALL drive s_ready = !out_vld || !full; with a word pending and the FIFO full, input stalls.
REQ-023 SHALL give one-cycle latency from the completing take to the first wren opportunity.
REQ-024 SHALL sustain one take per cycle and one FIFO write per RATIO cycles while full==0.
REQ-025 SHALL treat s_last at cnt==0 as a one-lane word (lanes 1..RATIO-1 zero).
REQ-026 SHALL drive busy = out_vld || (cnt!=0).
REQ-027 SHALL ignore s_data and s_last when no take occurs.
REQ-028 SHALL never assert wren while full==1, so words cannot be dropped.

Reset
REQ-029 SHALL, on rstn low, asynchronously clear cnt, acc, out_word and out_vld, giving wren=0, din=0, busy=0 and s_ready=1.
REQ-030 SHALL discard any partial or pending word on reset mid-operation; the first take after reset lands in lane 0.

Structure
REQ-031 SHALL be a single module with no sub-modules; zero-padding and lane placement use a parameterised mask generated in the module.
REQ-032 SHALL place no typedefs in a package; the IN_W/RATIO defaults live as localparams only.

Verification (IN_W=8, RATIO=4)
REQ-033 SHALL cover this scenario: takes 0x11,0x22,0x33,0x44 with full=0 -> one cycle later wren=1 with din=0x44332211, and exactly one write.
REQ-034 SHALL cover this scenario: takes 0xAA, then 0xBB with s_last=1 -> din=0x0000BBAA with wren=1, and the next take lands in lane 0.
REQ-035 SHALL cover this scenario: a word pending with full=1 held for 5 cycles -> wren=0 and s_ready=0 throughout, then full drops -> wren=1 once with the word unchanged.
REQ-036 SHALL cover this scenario: continuous s_valid=1 for 16 beats 0x00..0x0F with full=0 -> 4 writes 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, and no stall cycles.
REQ-037 SHALL cover this scenario: rstn pulsed low after 2 takes -> busy=0 and wren=0 immediately, then takes 0x01..0x04 -> din=0x04030201.
REQ-038 SHALL cover this scenario: pair with syncfifo (DWIDTH=32, AWIDTH=2), 6 words in and no reads -> 4 writes accepted, then stall, with full never coincident with wren.
